// File: rtl/uart_fb_pkg.sv
// Shared state encoding and stream command constants for the UART framebuffer loader.
package uart_fb_pkg;

    typedef enum logic [2:0] {
        S_COUNT,
        S_DATA,
        S_FILL,
        S_ESC,
        S_CLEAR
    } state_t;

    localparam logic [7:0] CMD_HOME     = 8'h00;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] ESCAPE_COUNT = 8'h00;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer memory: one write port, one registered read port.
// A read and write to the same address in one cycle return the old contents.
module fb_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // Both assignments are non-blocking, so the read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_framebuffer.sv
// Decodes a run-length-encoded UART byte stream into a page/column framebuffer
// and exposes an independent 1-cycle-latency random-access read port.
module uart_framebuffer
    import uart_fb_pkg::*;
#(
    parameter int COLUMNS = 128,
    parameter int PAGES   = 8,
    parameter int ADDR_W  = $clog2(COLUMNS * PAGES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_received,
    input  logic [7:0]                 uart_rx_byte,
    input  logic                       rd_en,
    input  logic [$clog2(PAGES)-1:0]   rd_page,
    input  logic [$clog2(COLUMNS)-1:0] rd_column,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int DEPTH = COLUMNS * PAGES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        count;
    logic [7:0]        value;
    logic              overrun_reg;
    logic              rd_valid_reg;

    logic              we;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        ram_q;

    assign we      = (state == S_FILL) || (state == S_CLEAR);
    assign wr_data = (state == S_FILL) ? value : 8'h00;
    // Geometry is power-of-two, so page*COLUMNS + column is a concatenation.
    assign rd_addr = {rd_page, rd_column};

    assign busy       = (state == S_FILL) || (state == S_CLEAR);
    assign frame_done = (state == S_FILL) && (ptr == LAST_ADDR);
    assign overrun    = overrun_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_valid_reg ? ram_q : 8'h00;

    fb_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (ptr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_COUNT;
            ptr         <= '0;
            count       <= 8'h00;
            value       <= 8'h00;
            overrun_reg <= 1'b0;
        end else begin
            case (state)
                S_COUNT: begin
                    if (uart_received) begin
                        if (uart_rx_byte == ESCAPE_COUNT) begin
                            state <= S_ESC;
                        end else begin
                            count <= uart_rx_byte;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (uart_received) begin
                        value <= uart_rx_byte;
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    ptr   <= ptr + 1'b1;
                    count <= count - 8'd1;
                    if (count == 8'd1) begin
                        state <= S_COUNT;
                    end
                    if (uart_received) begin
                        overrun_reg <= 1'b1;
                    end
                end
                S_ESC: begin
                    if (uart_received) begin
                        if (uart_rx_byte == CMD_HOME) begin
                            ptr   <= '0;
                            state <= S_COUNT;
                        end else if (uart_rx_byte == CMD_CLEAR) begin
                            ptr   <= '0;
                            state <= S_CLEAR;
                        end else begin
                            state <= S_COUNT;
                        end
                    end
                end
                S_CLEAR: begin
                    // Pointer wraps back to 0 naturally after the last address.
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state <= S_COUNT;
                    end
                    if (uart_received) begin
                        overrun_reg <= 1'b1;
                    end
                end
                default: begin
                    state <= S_COUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_framebuffer.sv
// Scoreboard bench for uart_framebuffer: expected read data is queued when a read
// is issued and compared when rd_valid returns it.
module tb_uart_framebuffer;

    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_received = 1'b0;
    logic [7:0] uart_rx_byte = 8'h00;
    logic       rd_en = 1'b0;
    logic [2:0] rd_page = 3'd0;
    logic [6:0] rd_column = 7'd0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    logic [7:0] model [DEPTH];
    int         ptr_m = 0;
    logic [7:0] sb_q [$];
    logic       exp_valid = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         frame_pulses = 0;

    uart_framebuffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_received (uart_received),
        .uart_rx_byte  (uart_rx_byte),
        .rd_en         (rd_en),
        .rd_page       (rd_page),
        .rd_column     (rd_column),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle read latency: a read sampled on this edge is valid on the next.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_valid <= 1'b0;
        else        exp_valid <= rd_en;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (rd_valid !== exp_valid) begin
                failures++;
                $display("FAIL rd_valid got=%0b exp=%0b t=%0t", rd_valid, exp_valid, $time);
            end
            if (exp_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty got=%02h exp=none t=%0t", rd_data, $time);
                end else begin
                    logic [7:0] e;
                    e = sb_q.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL rd_data got=%02h exp=%02h t=%0t", rd_data, e, $time);
                    end else begin
                        $display("read ok data=%02h t=%0t", rd_data, $time);
                    end
                end
            end
        end
    end

    task automatic issue_read(input int addr);
        logic [9:0] a;
        a = addr[9:0];
        rd_page   = a[9:7];
        rd_column = a[6:0];
        rd_en     = 1'b1;
        sb_q.push_back(model[a]);
    endtask

    task automatic read_range(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            issue_read((start + i) % DEPTH);
            @(negedge clk);
        end
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_received = 1'b1;
        uart_rx_byte  = b;
        @(negedge clk);
        uart_received = 1'b0;
    endtask

    // Sends one (count, value) pair and follows the fill cycle by cycle.
    task automatic drive_run(input int cnt, input logic [7:0] val, input int inject_at, input bit read_same);
        send_byte(8'(cnt));
        send_byte(val);
        for (int k = 0; k < cnt; k++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL fill_busy got=%0b exp=1 k=%0d", busy, k);
            end
            checks++;
            if (frame_done !== (ptr_m == DEPTH - 1)) begin
                failures++;
                $display("FAIL fill_frame_done got=%0b exp=%0b addr=%0d", frame_done, (ptr_m == DEPTH - 1), ptr_m);
            end
            if (frame_done === 1'b1) frame_pulses++;
            if (read_same) issue_read(ptr_m);
            else           rd_en = 1'b0;
            uart_received = (k == inject_at);
            uart_rx_byte  = 8'h07;
            model[ptr_m] = val;
            ptr_m = (ptr_m + 1) % DEPTH;
            @(negedge clk);
        end
        uart_received = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_end_busy got=%0b exp=0", busy);
        end
        $display("run count=%0d value=%02h end_ptr=%0d", cnt, val, ptr_m);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 5;
        if (rd_valid !== 1'b0)   begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        if (rd_data !== 8'h00)   begin failures++; $display("FAIL reset_rd_data got=%02h exp=00", rd_data); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
        if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        $display("reset checked");
    endtask

    task automatic test_clear();
        send_byte(8'h00);
        send_byte(8'h01);
        ptr_m = 0;
        for (int k = 0; k < DEPTH; k++) begin
            checks += 2;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL clear_busy got=%0b exp=1 k=%0d", busy, k);
            end
            if (frame_done !== 1'b0) begin
                failures++;
                $display("FAIL clear_frame_done got=%0b exp=0 k=%0d", frame_done, k);
            end
            model[k] = 8'h00;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_end_busy got=%0b exp=0", busy);
        end
        read_range(0, DEPTH);
        $display("clear checked");
    endtask

    task automatic test_first_run();
        drive_run(3, 8'hA5, -1, 1'b0);
        read_range(0, 4);
        drive_run(1, 8'h5A, -1, 1'b0);
        read_range(2, 3);
    endtask

    task automatic test_frame();
        send_byte(8'h00);
        send_byte(8'h00);
        ptr_m = 0;
        frame_pulses = 0;
        for (int p = 0; p < 4; p++) drive_run(255, 8'h11, -1, 1'b0);
        drive_run(4, 8'h22, -1, 1'b0);
        checks++;
        if (frame_pulses != 1) begin
            failures++;
            $display("FAIL frame_pulse_count got=%0d exp=1", frame_pulses);
        end
        read_range(1019, 2);
        read_range(1023, 1);
    endtask

    task automatic test_home();
        drive_run(5, 8'h33, -1, 1'b0);
        send_byte(8'h00);
        send_byte(8'h00);
        ptr_m = 0;
        drive_run(1, 8'h44, -1, 1'b0);
        read_range(0, 2);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL home_overrun got=%0b exp=0", overrun);
        end
    endtask

    task automatic test_overrun();
        drive_run(200, 8'h55, 10, 1'b0);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set got=%0b exp=1", overrun);
        end
        drive_run(2, 8'h77, -1, 1'b0);
        read_range(ptr_m - 3, 3);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got=%0b exp=1", overrun);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = ptr_m;
        drive_run(4, 8'h99, -1, 1'b1);
        read_range(start, 4);
    endtask

    task automatic test_reset_midfill();
        int start;
        start = ptr_m;
        send_byte(8'd50);
        send_byte(8'h66);
        for (int k = 0; k < 5; k++) begin
            model[(start + k) % DEPTH] = 8'h66;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0)       begin failures++; $display("FAIL midfill_reset_busy got=%0b exp=0", busy); end
        if (overrun !== 1'b0)    begin failures++; $display("FAIL midfill_reset_overrun got=%0b exp=0", overrun); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL midfill_reset_frame_done got=%0b exp=0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ptr_m = 0;
        drive_run(1, 8'hC3, -1, 1'b0);
        read_range(0, 1);
        read_range(start + 4, 2);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_first_run();
        test_frame();
        test_home();
        test_overrun();
        test_back_to_back();
        test_reset_midfill();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
